pattern_stream_buf: RTL and testbench

Parametrised single-clock pattern buffer and serialiser between the camera pattern FIFO and the sensor MSTREAM pins. It pulls IN_W-bit pattern words from an upstream FIFO, stores up to DEPTH of them, and slices them into OUT_W-bit MSTREAM beats on demand from the sensor timing logic. It adds a pattern-count limit, one-shot and loop modes, completion and underflow status, and config checking.

---
 rtl/pattern_stream_buf.sv | 191 +++++++++++++++++++
 tb/tb_pattern_stream_buf.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_stream_buf.sv
// Pattern word buffer between the camera pattern FIFO and the sensor MSTREAM pins.
// Fills from upstream, then slices each IN_W word into OUT_W beats LSB-first, in one-shot or loop-replay mode.
module pattern_stream_buf #(
    parameter int IN_W  = 256,
    parameter int OUT_W = 16,
    parameter int DEPTH = 512,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic             loop_mode,
    input  logic [IN_W-1:0]  pat_in,
    input  logic             pat_empty,
    input  logic             pat_valid,
    output logic             pat_rd_en,
    input  logic             stream_en_i,
    output logic [OUT_W-1:0] mstream_out,
    output logic             stream_en_o,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic             cfg_err,
    output logic [CNT_W-1:0] words_loaded
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NSL = IN_W / OUT_W;
    localparam int SW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [SW-1:0]    SLICE_LAST = SW'(NSL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, LOOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_pat_q, num_pat_d;
    logic             loop_q, loop_d;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic             inflight_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      used_q, used_d;
    logic [CNT_W-1:0] words_loaded_q, words_loaded_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [SW-1:0]    slice_q, slice_d;
    logic [OUT_W-1:0] mstream_out_q, mstream_out_d;
    logic             stream_en_o_q, stream_en_o_d;
    logic             done_q, done_d;
    logic             underflow_q, underflow_d;
    logic             cfg_err_q, cfg_err_d;

    logic [IN_W-1:0]  word_mem [DEPTH];
    logic [IN_W-1:0]  rd_word;
    logic [OUT_W-1:0] cur_slice;
    logic             capture, avail, accept, retire, last_word;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // A returning word is only taken if we actually asked for it last cycle.
    assign capture   = pat_valid & inflight_q;
    // Loop mode never frees words, so availability means "this word has been loaded".
    assign avail     = (state_q != IDLE) &&
                       (loop_q ? ({1'b0, rd_ptr_q} < used_q) : (used_q != '0));
    assign accept    = stream_en_i & avail;
    assign retire    = accept & (slice_q == SLICE_LAST);
    assign last_word = !loop_q && (rd_cnt_q == num_pat_q - 1'b1);
    assign rd_word   = word_mem[rd_ptr_q];
    assign cur_slice = rd_word[slice_q * OUT_W +: OUT_W];

    assign pat_rd_en = (state_q == FILL) && !pat_empty && (req_cnt_q < num_pat_q) &&
                       (((AW+2)'(used_q) + (AW+2)'(inflight_q)) < (AW+2)'(DEPTH));

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d        = state_q;
        num_pat_d      = num_pat_q;
        loop_d         = loop_q;
        req_cnt_d      = req_cnt_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        used_d         = used_q;
        words_loaded_d = words_loaded_q;
        rd_cnt_d       = rd_cnt_q;
        slice_d        = slice_q;
        mstream_out_d  = mstream_out_q;
        stream_en_o_d  = stream_en_i;
        done_d         = 1'b0;
        underflow_d    = underflow_q;
        cfg_err_d      = cfg_err_q;

        if (stream_en_i) begin
            mstream_out_d = accept ? cur_slice : '0;
            if (!avail) underflow_d = 1'b1;
        end
        if (pat_rd_en) req_cnt_d = sat_inc(req_cnt_q);
        if (capture) begin
            wr_ptr_d       = wr_ptr_q + 1'b1;
            words_loaded_d = sat_inc(words_loaded_q);
        end
        if (accept) slice_d = retire ? '0 : slice_q + 1'b1;
        if (retire) begin
            rd_cnt_d = sat_inc(rd_cnt_q);
            if (loop_q && (CNT_W'(rd_ptr_q) == num_pat_q - 1'b1)) rd_ptr_d = '0;
            else                                                  rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({capture, retire && !loop_q})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
        endcase

        case (state_q)
            IDLE: if (start) begin
                if (loop_mode && (num_pat > DEPTH_CNT)) cfg_err_d = 1'b1;
                num_pat_d      = num_pat;
                loop_d         = loop_mode && !(num_pat > DEPTH_CNT);
                req_cnt_d      = '0;
                wr_ptr_d       = '0;
                rd_ptr_d       = '0;
                used_d         = '0;
                words_loaded_d = '0;
                rd_cnt_d       = '0;
                slice_d        = '0;
                if (num_pat == '0) done_d  = 1'b1;
                else               state_d = FILL;
            end
            FILL: if ((req_cnt_q == num_pat_q) && !inflight_q) state_d = loop_q ? LOOP : DRAIN;
            default: ;
        endcase

        if ((state_q != IDLE) && retire && last_word) begin
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            num_pat_q      <= '0;
            loop_q         <= 1'b0;
            req_cnt_q      <= '0;
            inflight_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            used_q         <= '0;
            words_loaded_q <= '0;
            rd_cnt_q       <= '0;
            slice_q        <= '0;
            mstream_out_q  <= '0;
            stream_en_o_q  <= 1'b0;
            done_q         <= 1'b0;
            underflow_q    <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_pat_q      <= num_pat_d;
            loop_q         <= loop_d;
            req_cnt_q      <= req_cnt_d;
            inflight_q     <= pat_rd_en;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            used_q         <= used_d;
            words_loaded_q <= words_loaded_d;
            rd_cnt_q       <= rd_cnt_d;
            slice_q        <= slice_d;
            mstream_out_q  <= mstream_out_d;
            stream_en_o_q  <= stream_en_o_d;
            done_q         <= done_d;
            underflow_q    <= underflow_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    // NOTE: the word store has no reset; every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (capture) word_mem[wr_ptr_q] <= pat_in;
    end

    assign mstream_out  = mstream_out_q;
    assign stream_en_o  = stream_en_o_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign underflow    = underflow_q;
    assign cfg_err      = cfg_err_q;
    assign words_loaded = words_loaded_q;
endmodule

// File: tb/tb_pattern_stream_buf.sv
// Self-checking bench for pattern_stream_buf: a scenario table for whole runs plus
// hand-written sequences for back-pressure, starvation gaps and reset mid-run.
module tb_pattern_stream_buf;
    localparam int IN_W  = 256;
    localparam int OUT_W = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;
    localparam int BPW   = IN_W / OUT_W;

    logic             clk = 1'b0;
    logic             reset_n, start, loop_mode, pat_empty, pat_valid, stream_en_i;
    logic [CNT_W-1:0] num_pat;
    logic [IN_W-1:0]  pat_in;
    logic             pat_rd_en, stream_en_o, busy, done, underflow, cfg_err;
    logic [OUT_W-1:0] mstream_out;
    logic [CNT_W-1:0] words_loaded;

    pattern_stream_buf #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_pat(num_pat), .loop_mode(loop_mode),
        .pat_in(pat_in), .pat_empty(pat_empty), .pat_valid(pat_valid), .pat_rd_en(pat_rd_en),
        .stream_en_i(stream_en_i), .mstream_out(mstream_out), .stream_en_o(stream_en_o),
        .busy(busy), .done(done), .underflow(underflow), .cfg_err(cfg_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        int num_pat;
        bit loop;
        int beats;
        int exp_done;
        bit exp_cfg;
        bit exp_busy;
        int exp_loaded;
    } vec_t;

    vec_t vecs[7];
    int   checks, errors;
    int   src_cnt, src_req, done_cnt, starved, got;
    bit   gap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte i of word w; odd words are the complement of the preceding even word.
    function automatic logic [IN_W-1:0] gen_word(input int w);
        logic [IN_W-1:0] r;
        for (int i = 0; i < IN_W / 8; i++)
            r[i*8 +: 8] = 8'(i + 32 * (w / 2)) ^ ((w % 2 == 1) ? 8'hFF : 8'h00);
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] exp_beat(input int b, input int np, input bit lp);
        logic [IN_W-1:0] w;
        int idx;
        idx = b / BPW;
        if (lp) idx = idx % np;
        w = gen_word(idx);
        return w[(b % BPW) * OUT_W +: OUT_W];
    endfunction

    // One clock; the upstream FIFO returns data one clock after each sampled request.
    task automatic cycle();
        logic rd;
        @(negedge clk);
        rd = pat_rd_en;
        @(posedge clk);
        #1;
        // NOTE: bench inputs are driven with blocking assignments away from the edge.
        pat_valid = rd;
        if (rd) begin
            pat_in = gen_word(src_req);
            src_req++;
        end
        pat_empty = (src_req >= src_cnt) || (gap && ($urandom_range(0, 9) != 0));
        if (done) done_cnt++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0;
        stream_en_i = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic start_run(input int np, input bit lm);
        src_cnt  = np;
        src_req  = 0;
        done_cnt = 0;
        pat_empty = (np == 0);
        num_pat   = np;
        loop_mode = lm;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    // Holds stream_en_i until `want` data beats are seen; zero beats count as starved when allowed.
    task automatic stream(input int np, input bit lp, input int want, input int budget, input bit allow_starve);
        got = 0;
        starved = 0;
        stream_en_i = 1'b1;
        for (int c = 0; c < budget && got < want; c++) begin
            cycle();
            if (stream_en_o) begin
                if (allow_starve && mstream_out == '0) starved++;
                else begin
                    check($sformatf("beat_%0d", got), mstream_out, exp_beat(got, np, lp));
                    if (!lp && got == np * BPW - 1) begin
                        check("done_with_last_beat", done, 1);
                        check("busy_low_after_last", busy, 0);
                    end
                    got++;
                end
            end
            if (got >= want) stream_en_i = 1'b0;
        end
        stream_en_i = 1'b0;
        check("beat_count", got, want);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_underflow"}, underflow, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_words_loaded"}, words_loaded, 0);
        check({tag, "_mstream_out"}, mstream_out, 0);
        check({tag, "_stream_en_o"}, stream_en_o, 0);
        check({tag, "_pat_rd_en"}, pat_rd_en, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lp_eff;
        checks = 0; errors = 0;
        src_cnt = 0; src_req = 0; done_cnt = 0; gap = 1'b0;
        reset_n = 1'b0; start = 1'b0; loop_mode = 1'b0; num_pat = '0;
        pat_in = '0; pat_empty = 1'b1; pat_valid = 1'b0; stream_en_i = 1'b0;

        //          num_pat loop beats done cfg  busy loaded
        vecs[0] = '{2,      1'b0, 32,  1, 1'b0, 1'b0, 2};
        vecs[1] = '{3,      1'b1, 100, 0, 1'b0, 1'b1, 3};
        vecs[2] = '{9,      1'b1, 144, 1, 1'b1, 1'b0, 9};
        vecs[3] = '{1,      1'b0, 16,  1, 1'b0, 1'b0, 1};
        vecs[4] = '{0,      1'b0, 0,   1, 1'b0, 1'b0, 0};
        vecs[5] = '{8,      1'b0, 128, 1, 1'b0, 1'b0, 8};
        vecs[6] = '{8,      1'b1, 200, 0, 1'b0, 1'b1, 8};

        do_reset();
        check_all_zero("reset");

        foreach (vecs[i]) begin
            lp_eff = vecs[i].loop && !vecs[i].exp_cfg;
            do_reset();
            start_run(vecs[i].num_pat, vecs[i].loop);
            check($sformatf("v%0d_busy_after_start", i), busy, vecs[i].num_pat != 0);
            check($sformatf("v%0d_done_after_start", i), done, vecs[i].num_pat == 0);
            if (vecs[i].beats > 0) begin
                cycle();
                cycle();
                stream(vecs[i].num_pat, lp_eff, vecs[i].beats, vecs[i].beats + 50, 1'b0);
            end
            repeat (3) cycle();
            check($sformatf("v%0d_done_pulses", i), done_cnt, vecs[i].exp_done);
            check($sformatf("v%0d_cfg_err", i), cfg_err, vecs[i].exp_cfg);
            check($sformatf("v%0d_busy_end", i), busy, vecs[i].exp_busy);
            check($sformatf("v%0d_words_loaded", i), words_loaded, vecs[i].exp_loaded);
            check($sformatf("v%0d_underflow", i), underflow, 0);
            check($sformatf("v%0d_pat_rd_en_end", i), pat_rd_en, 0);
            if (vecs[i].beats > 0)
                check($sformatf("v%0d_hold_last", i), mstream_out,
                      exp_beat(vecs[i].beats - 1, vecs[i].num_pat, lp_eff));
        end

        // Back-pressure: buffer fills to DEPTH and requests stop until beats drain it.
        do_reset();
        start_run(20, 1'b0);
        repeat (50) cycle();
        check("bp_words_loaded_full", words_loaded, DEPTH);
        check("bp_pat_rd_en_low", pat_rd_en, 0);
        check("bp_busy", busy, 1);
        stream(20, 1'b0, 20 * BPW, 20 * BPW + 50, 1'b0);
        repeat (3) cycle();
        check("bp_done_pulses", done_cnt, 1);
        check("bp_underflow", underflow, 0);
        check("bp_words_loaded_end", words_loaded, 20);

        // Starvation: sparse upstream data with beats requested every clock.
        do_reset();
        gap = 1'b1;
        start_run(6, 1'b0);
        stream(6, 1'b0, 6 * BPW, 3000, 1'b1);
        gap = 1'b0;
        repeat (3) cycle();
        check("gap_underflow_set", underflow, 1);
        check("gap_starved_seen", starved > 0, 1);
        check("gap_done_pulses", done_cnt, 1);
        check("gap_busy_end", busy, 0);
        check("gap_words_loaded", words_loaded, 6);

        // Reset in DRAIN, then a fresh run.
        do_reset();
        start_run(4, 1'b0);
        cycle();
        cycle();
        stream(4, 1'b0, 40, 100, 1'b0);
        check("mid_words_loaded", words_loaded, 4);
        check("mid_busy", busy, 1);
        check("mid_pat_rd_en", pat_rd_en, 0);
        stream_en_i = 1'b1;
        reset_n = 1'b0;
        cycle();
        check_all_zero("mid_reset");
        reset_n = 1'b1;
        stream_en_i = 1'b0;
        start_run(2, 1'b0);
        cycle();
        cycle();
        stream(2, 1'b0, 2 * BPW, 2 * BPW + 50, 1'b0);
        repeat (3) cycle();
        check("rerun_done_pulses", done_cnt, 1);
        check("rerun_underflow", underflow, 0);
        check("rerun_busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
